// File: rtl/sprite_palette_lut.sv
// sprite_palette_lut: programmable multi-bank sprite palette with a two-stage lookup pipeline.
// After reset an INIT sweep clears every entry, then READY accepts palette writes and lookups.
// Optional macro PALETTE_FADE_EN: scales every looked-up channel by (16 - fade_level)/16.
module sprite_palette_lut #(
  parameter  int INDEX_W      = 4,
  parameter  int CH_W         = 4,
  parameter  int NUM_BANKS    = 4,
  parameter  int TRANSP_INDEX = 0,
  localparam int BANK_W       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pix_valid_in,
  input  logic [INDEX_W-1:0]  pix_index,
  input  logic [BANK_W-1:0]   pix_bank,
  input  logic [3:0]          fade_level,
  output logic                pix_valid_out,
  output logic [CH_W-1:0]     red,
  output logic [CH_W-1:0]     green,
  output logic [CH_W-1:0]     blue,
  output logic                pix_transparent,
  input  logic                wr_en,
  input  logic [BANK_W-1:0]   wr_bank,
  input  logic [INDEX_W-1:0]  wr_addr,
  input  logic [3*CH_W-1:0]   wr_data,
  output logic                wr_ready
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int ADDR_W  = BANK_W + INDEX_W;
  localparam int DEPTH   = NUM_BANKS * ENTRIES;
  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [BANK_W:0]    BANK_LIMIT = (BANK_W + 1)'(NUM_BANKS);
  localparam logic [INDEX_W-1:0] TRANSP_KEY = INDEX_W'(TRANSP_INDEX);

  typedef enum logic {INIT, READY} state_t;

  state_t state, state_nxt;

  // Storage is addressed as {bank, index}; bank sits in the high bits so the INIT sweep
  // over 0..DEPTH-1 clears exactly the real banks even when NUM_BANKS is not a power of two.
  logic [3*CH_W-1:0] mem [0:(1 << ADDR_W)-1];

  logic [ADDR_W-1:0] clr_cnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3*CH_W-1:0] mem_wdata;
  logic              wr_bank_ok;
  logic              rd_bank_ok;
  logic [ADDR_W-1:0] rd_addr;
  logic              bypass;

  logic              s1_valid;
  logic              s1_transp;
  logic [3*CH_W-1:0] s1_data;
  logic [CH_W-1:0]   r_mod, g_mod, b_mod;

  assign wr_bank_ok = ({1'b0, wr_bank} < BANK_LIMIT);
  assign rd_bank_ok = ({1'b0, pix_bank} < BANK_LIMIT);
  assign rd_addr    = {pix_bank, pix_index};
  assign bypass     = (state == READY) && mem_we && (mem_addr == rd_addr);

  // State register: INIT after any reset, READY once the clear sweep has finished.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= state_nxt;
  end

  // Next state and storage write-port steering: clear sweep in INIT, user writes in READY.
  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = clr_cnt;
    mem_wdata = '0;
    case (state)
      INIT: begin
        mem_we = 1'b1;
        if (clr_cnt == LAST_ADDR) state_nxt = READY;
      end
      READY: begin
        wr_ready  = 1'b1;
        mem_we    = wr_en && wr_bank_ok;
        mem_addr  = {wr_bank, wr_addr};
        mem_wdata = wr_data;
      end
      default: state_nxt = INIT;
    endcase
  end

  // Clear-sweep address counter, advancing once per INIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              clr_cnt <= '0;
    else if (state == INIT)  clr_cnt <= clr_cnt + ADDR_W'(1);
  end

  // Palette storage write port.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Stage 1: registered read with write-first bypass; out-of-range banks read as black.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_transp <= 1'b0;
      s1_data   <= '0;
    end else begin
      s1_valid <= pix_valid_in && (state == READY);
      if (pix_valid_in) begin
        s1_transp <= (pix_index == TRANSP_KEY);
        if (!rd_bank_ok)  s1_data <= '0;
        else if (bypass)  s1_data <= wr_data;
        else              s1_data <= mem[rd_addr];
      end
    end
  end

`ifdef PALETTE_FADE_EN
  logic [3:0] s1_fade;

  function automatic logic [CH_W-1:0] fade_ch(input logic [CH_W-1:0] ch, input logic [3:0] lvl);
    logic [CH_W+4:0] prod;
    prod = (CH_W + 5)'(ch) * ((CH_W + 5)'(16) - (CH_W + 5)'(lvl));
    return CH_W'(prod >> 4);
  endfunction

  // Fade amount travels with its request through stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            s1_fade <= '0;
    else if (pix_valid_in) s1_fade <= fade_level;
  end

  assign r_mod = fade_ch(s1_data[3*CH_W-1:2*CH_W], s1_fade);
  assign g_mod = fade_ch(s1_data[2*CH_W-1:CH_W],   s1_fade);
  assign b_mod = fade_ch(s1_data[CH_W-1:0],        s1_fade);
`else
  logic unused_fade;
  assign unused_fade = ^fade_level;

  assign r_mod = s1_data[3*CH_W-1:2*CH_W];
  assign g_mod = s1_data[2*CH_W-1:CH_W];
  assign b_mod = s1_data[CH_W-1:0];
`endif

  // Stage 2: output registers; colour holds between valid pixels, transparent key forces black.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid_out   <= 1'b0;
      pix_transparent <= 1'b0;
      red             <= '0;
      green           <= '0;
      blue            <= '0;
    end else begin
      pix_valid_out <= s1_valid;
      if (s1_valid) begin
        pix_transparent <= s1_transp;
        red             <= s1_transp ? '0 : r_mod;
        green           <= s1_transp ? '0 : g_mod;
        blue            <= s1_transp ? '0 : b_mod;
      end
    end
  end

endmodule

// File: tb/tb_sprite_palette_lut.sv
// tb_sprite_palette_lut: directed and randomized checks of sprite_palette_lut against a
// palette-array reference model with a two-cycle expected-result queue.
module tb_sprite_palette_lut;

  localparam int INDEX_W      = 4;
  localparam int CH_W         = 4;
  localparam int NUM_BANKS    = 4;
  localparam int TRANSP_INDEX = 0;
  localparam int ENTRIES      = 16;
  localparam int INIT_CYCLES  = NUM_BANKS * ENTRIES;
`ifdef PALETTE_FADE_EN
  localparam int FADE_EN = 1;
`else
  localparam int FADE_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_valid_in;
  logic [3:0]  pix_index;
  logic [1:0]  pix_bank;
  logic [3:0]  fade_level;
  logic        pix_valid_out;
  logic [3:0]  red, green, blue;
  logic        pix_transparent;
  logic        wr_en;
  logic [1:0]  wr_bank;
  logic [3:0]  wr_addr;
  logic [11:0] wr_data;
  logic        wr_ready;

  sprite_palette_lut #(
    .INDEX_W(INDEX_W), .CH_W(CH_W), .NUM_BANKS(NUM_BANKS), .TRANSP_INDEX(TRANSP_INDEX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pix_valid_in(pix_valid_in), .pix_index(pix_index), .pix_bank(pix_bank),
    .fade_level(fade_level),
    .pix_valid_out(pix_valid_out), .red(red), .green(green), .blue(blue),
    .pix_transparent(pix_transparent),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready)
  );

  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          edges  = 0;
  int          pal [NUM_BANKS][ENTRIES];
  logic [13:0] exp_q [$];
  logic [12:0] held;

  // Reference pixel: {transparent, R, G, B} from an entry colour using plain arithmetic.
  function automatic logic [12:0] model_pixel(input int idx, input int fade, input int colour);
    int ch [3];
    int scale;
    if (idx == TRANSP_INDEX) return {1'b1, 12'h000};
    scale = 16 - ((FADE_EN != 0) ? fade : 0);
    ch[0] = ((colour >> 8) & 15) * scale / 16;
    ch[1] = ((colour >> 4) & 15) * scale / 16;
    ch[2] = (colour & 15) * scale / 16;
    return {1'b0, 4'(ch[0]), 4'(ch[1]), 4'(ch[2])};
  endfunction

  task automatic checkOutput(input string tag);
    logic [13:0] e, expv, obs;
    logic        exp_ready;
    exp_ready = (edges >= INIT_CYCLES);
    n_cmp++;
    assert (wr_ready === exp_ready) else begin
      n_fail++;
      $error("[TB] FAIL %s wr_ready observed=%0b expected=%0b", tag, wr_ready, exp_ready);
    end
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      if (e[13]) held = e[12:0];
      expv = {e[13], held};
      obs  = {pix_valid_out, pix_transparent, red, green, blue};
      n_cmp++;
      assert (obs === expv) else begin
        n_fail++;
        $error("[TB] FAIL %s pixel {v,t,rgb} observed=%h expected=%h", tag, obs, expv);
      end
    end
  endtask

  // One clock cycle: drive request/write, predict its result, advance, and check.
  task automatic applyStimulus(input string tag, input bit v, input int bank, input int idx,
                               input int fade, input bit we, input int wb, input int wa,
                               input int wd);
    bit          ready;
    int          colour;
    logic [13:0] e;
    ready        = (edges >= INIT_CYCLES);
    pix_valid_in = v;
    pix_bank     = 2'(bank);
    pix_index    = 4'(idx);
    fade_level   = 4'(fade);
    wr_en        = we;
    wr_bank      = 2'(wb);
    wr_addr      = 4'(wa);
    wr_data      = 12'(wd);
    e = '0;
    if (v && ready) begin
      colour = (we && wb == bank && wa == idx) ? wd : pal[bank][idx];
      e = {1'b1, model_pixel(idx, fade, colour)};
    end
    if (we && ready) pal[wb][wa] = wd;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    edges++;
    checkOutput(tag);
  endtask

  task automatic applyReset(input string tag);
    logic [13:0] obs;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    obs = {pix_valid_out, pix_transparent, red, green, blue};
    n_cmp++;
    assert (obs === 14'h0) else begin
      n_fail++;
      $error("[TB] FAIL %s outputs observed=%h expected=%h", tag, obs, 14'h0);
    end
    n_cmp++;
    assert (wr_ready === 1'b0) else begin
      n_fail++;
      $error("[TB] FAIL %s wr_ready observed=%0b expected=0", tag, wr_ready);
    end
    pix_valid_in = 0; pix_index = 0; pix_bank = 0; fade_level = 0;
    wr_en = 0; wr_bank = 0; wr_addr = 0; wr_data = 0;
    exp_q.delete();
    held = '0;
    foreach (pal[b, i]) pal[b][i] = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
  endtask

  initial begin
    bit v, we;
    int bank, idx, fade, wb, wa, wd;
    rst_n = 1'b1;
    pix_valid_in = 0; pix_index = 0; pix_bank = 0; fade_level = 0;
    wr_en = 0; wr_bank = 0; wr_addr = 0; wr_data = 0;
    held = '0;

    applyReset("reset");

    // Lookups and writes during the clear sweep must be ignored; wr_ready rises after 64 edges.
    for (int i = 0; i < 70; i++)
      applyStimulus("init", 1'b1, i % 4, (i % 15) + 1, 0, 1'b1, (i + 1) % 4, i % 16, 12'hFFF);

    // Simple write then lookup.
    applyStimulus("wr_b1i5", 0, 0, 0, 0, 1, 1, 5, 12'hF76);
    applyStimulus("rd_b1i5", 1, 1, 5, 0, 0, 0, 0, 0);
    applyStimulus("idle", 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("idle", 0, 0, 0, 0, 0, 0, 0, 0);

    // Back-to-back lookups, then the transparent key.
    for (int i = 1; i <= 4; i++)
      applyStimulus("wr_seq", 0, 0, 0, 0, 1, 1, i, 12'h123 * i);
    for (int i = 1; i <= 4; i++)
      applyStimulus("b2b", 1, 1, i, 0, 0, 0, 0, 0);
    applyStimulus("transp", 1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus("idle", 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("idle", 0, 0, 0, 0, 0, 0, 0, 0);

    // Same-cycle write and lookup of one entry returns the new data.
    applyStimulus("bypass", 1, 0, 3, 0, 1, 0, 3, 12'hAEA);
    // Write landing one cycle after a lookup must not alter that in-flight pixel.
    applyStimulus("inflight", 1, 1, 5, 0, 0, 0, 0, 0);
    applyStimulus("inflight_wr", 0, 0, 0, 0, 1, 1, 5, 12'h3C1);
    applyStimulus("inflight_rd", 1, 1, 5, 0, 0, 0, 0, 0);
    applyStimulus("idle", 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("idle", 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef PALETTE_FADE_EN
    applyStimulus("fade_wr", 0, 0, 0, 0, 1, 2, 7, 12'hF80);
    applyStimulus("fade8", 1, 2, 7, 8, 0, 0, 0, 0);
    applyStimulus("fade0", 1, 2, 7, 0, 0, 0, 0, 0);
    applyStimulus("fade15", 1, 2, 7, 15, 0, 0, 0, 0);
    applyStimulus("idle", 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("idle", 0, 0, 0, 0, 0, 0, 0, 0);
`endif

    // Randomized traffic with frequent same-entry write/read collisions.
    for (int i = 0; i < 200; i++) begin
      v    = 1'($urandom_range(0, 1));
      bank = $urandom_range(0, NUM_BANKS - 1);
      idx  = $urandom_range(0, ENTRIES - 1);
      fade = $urandom_range(0, 15);
      we   = 1'($urandom_range(0, 1));
      wb   = $urandom_range(0, NUM_BANKS - 1);
      wa   = $urandom_range(0, ENTRIES - 1);
      wd   = $urandom_range(0, 4095);
      if ($urandom_range(0, 3) == 0) begin
        wb = bank;
        wa = idx;
      end
      applyStimulus("random", v, bank, idx, fade, we, wb, wa, wd);
    end

    // Reset with pixels in flight; palette must come back cleared.
    applyStimulus("pre_rst_wr", 0, 0, 0, 0, 1, 1, 5, 12'hF76);
    applyStimulus("pre_rst", 1, 1, 5, 0, 0, 0, 0, 0);
    applyStimulus("pre_rst", 1, 1, 5, 0, 0, 0, 0, 0);
    applyReset("mid_reset");
    for (int i = 0; i < 66; i++)
      applyStimulus("reinit", 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("cleared", 1, 1, 5, 0, 0, 0, 0, 0);
    applyStimulus("idle", 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("idle", 0, 0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
